// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [1:0] DSEL_PC = 2'b00;
    localparam logic [1:0] DSEL_DL = 2'b01;
    localparam logic [1:0] DSEL_DM = 2'b10;

    localparam logic [1:0] RSEL_R31 = 2'b00;
    localparam logic [1:0] RSEL_RT  = 2'b01;
    localparam logic [1:0] RSEL_RD  = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HI   = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_IF0  = 4'd1,
        S_IF1  = 4'd2,
        S_ID   = 4'd3,
        S_EX   = 4'd4,
        S_WB   = 4'd5,
        S_MA   = 4'd6,
        S_MR   = 4'd7,
        S_MWB  = 4'd8,
        S_MW   = 4'd9,
        S_BR   = 4'd10,
        S_JMP  = 4'd11,
        S_HALT = 4'd12
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_ALU_R, C_ALU_I, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR
    } cls_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - op/funct to instruction class and EX-phase controls
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output cls_t       cls,
    output logic [3:0] aluop,
    output logic [1:0] extop,
    output logic       sel,
    output logic [1:0] r_sel
);

    always_comb begin
        cls   = C_ILL;
        aluop = ALU_ADD;
        extop = EXT_ZERO;
        sel   = 1'b0;
        r_sel = RSEL_RD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin cls = C_ALU_R; aluop = ALU_ADD; end
                    FN_SUBU: begin cls = C_ALU_R; aluop = ALU_SUB; end
                    FN_AND:  begin cls = C_ALU_R; aluop = ALU_AND; end
                    FN_OR:   begin cls = C_ALU_R; aluop = ALU_OR;  end
                    FN_SLT:  begin cls = C_ALU_R; aluop = ALU_SLT; end
                    FN_JR:   cls = C_JR;
                    default: cls = C_ILL;
                endcase
            end
            OP_ORI: begin
                cls = C_ALU_I; aluop = ALU_OR; extop = EXT_ZERO; sel = 1'b1; r_sel = RSEL_RT;
            end
            OP_ADDIU: begin
                cls = C_ALU_I; aluop = ALU_ADD; extop = EXT_SIGN; sel = 1'b1; r_sel = RSEL_RT;
            end
            // lui is executed as (rs=0) | (imm<<16)
            OP_LUI: begin
                cls = C_ALU_I; aluop = ALU_OR; extop = EXT_HI; sel = 1'b1; r_sel = RSEL_RT;
            end
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            OP_BEQ:  cls = C_BEQ;
            OP_J:    cls = C_J;
            OP_JAL:  cls = C_JAL;
            default: cls = C_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle control FSM sequencing the MIPS datapath
module mc_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W      = 4,
    parameter int ILLEGAL_TRAP = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               PCWr,
    output logic [1:0]         npcop,
    output logic               IRWr,
    output logic               RFWr,
    output logic [1:0]         R_sel,
    output logic [1:0]         D_sel,
    output logic               sel,
    output logic [1:0]         extop,
    output logic [3:0]         aluop,
    output logic               wren,
    output logic               illegal,
    output logic [STATE_W-1:0] state_o
);

    state_t     state_q;
    cls_t       cls;
    logic [3:0] dec_aluop;
    logic [1:0] dec_extop;
    logic       dec_sel;
    logic [1:0] dec_r_sel;

    mc_ctrl_decode u_decode (
        .op    (op),
        .funct (funct),
        .cls   (cls),
        .aluop (dec_aluop),
        .extop (dec_extop),
        .sel   (dec_sel),
        .r_sel (dec_r_sel)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RST;
        end else begin
            case (state_q)
                S_RST: state_q <= S_IF0;
                S_IF0: state_q <= S_IF1;
                S_IF1: state_q <= S_ID;
                S_ID: begin
                    case (cls)
                        C_ALU_R, C_ALU_I: state_q <= S_EX;
                        C_LW, C_SW:       state_q <= S_MA;
                        C_BEQ:            state_q <= S_BR;
                        C_J, C_JAL, C_JR: state_q <= S_JMP;
                        default:          state_q <= (ILLEGAL_TRAP != 0) ? S_HALT : S_IF0;
                    endcase
                end
                S_EX:   state_q <= S_WB;
                S_MA:   state_q <= (cls == C_LW) ? S_MR : S_MW;
                S_MR:   state_q <= S_MWB;
                S_HALT: state_q <= S_HALT;
                S_WB, S_MWB, S_MW, S_BR, S_JMP: state_q <= S_IF0;
                default: state_q <= S_RST;
            endcase
        end
    end

    // Outputs decode only the state register and the stable IR fields, so they
    // hold steady for the whole state and clear as soon as reset asserts.
    always_comb begin
        PCWr    = 1'b0;
        npcop   = NPC_PC4;
        IRWr    = 1'b0;
        RFWr    = 1'b0;
        R_sel   = RSEL_R31;
        D_sel   = DSEL_PC;
        sel     = 1'b0;
        extop   = EXT_ZERO;
        aluop   = ALU_ADD;
        wren    = 1'b0;
        illegal = 1'b0;
        case (state_q)
            S_IF1: begin
                IRWr = 1'b1;
                PCWr = 1'b1;
            end
            S_ID: illegal = (cls == C_ILL);
            S_EX: begin
                sel   = dec_sel;
                extop = dec_extop;
                aluop = dec_aluop;
            end
            S_WB: begin
                RFWr  = 1'b1;
                D_sel = DSEL_DL;
                R_sel = dec_r_sel;
                sel   = dec_sel;
                extop = dec_extop;
                aluop = dec_aluop;
            end
            S_MA: begin
                sel   = 1'b1;
                extop = EXT_SIGN;
            end
            S_MWB: begin
                RFWr  = 1'b1;
                D_sel = DSEL_DM;
                R_sel = RSEL_RT;
            end
            S_MW: wren = 1'b1;
            S_BR: begin
                aluop = ALU_SUB;
                PCWr  = zero;
                npcop = NPC_BR;
            end
            S_JMP: begin
                PCWr  = 1'b1;
                npcop = (cls == C_JR) ? NPC_JR : NPC_JMP;
                RFWr  = (cls == C_JAL);
            end
            default: ;
        endcase
    end

    assign state_o = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

    localparam logic [3:0] ST_RST = 4'd0, ST_IF0 = 4'd1, ST_IF1 = 4'd2, ST_ID = 4'd3,
                           ST_EX = 4'd4, ST_WB = 4'd5, ST_MA = 4'd6, ST_MR = 4'd7,
                           ST_MWB = 4'd8, ST_MW = 4'd9, ST_BR = 4'd10, ST_JMP = 4'd11,
                           ST_HALT = 4'd12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] op = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;

    logic       pcwr, irwr, rfwr, sel, wren, illegal;
    logic [1:0] npcop, r_sel, d_sel, extop;
    logic [3:0] aluop, state_o;
    logic       pcwr_t, irwr_t, rfwr_t, sel_t, wren_t, illegal_t;
    logic [1:0] npcop_t, r_sel_t, d_sel_t, extop_t;
    logic [3:0] aluop_t, state_t_o;

    int total = 0;
    int bad = 0;

    mc_ctrl_fsm #(.STATE_W(4), .ILLEGAL_TRAP(0)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .PCWr(pcwr), .npcop(npcop), .IRWr(irwr), .RFWr(rfwr), .R_sel(r_sel),
        .D_sel(d_sel), .sel(sel), .extop(extop), .aluop(aluop), .wren(wren),
        .illegal(illegal), .state_o(state_o)
    );

    mc_ctrl_fsm #(.STATE_W(4), .ILLEGAL_TRAP(1)) dut_t (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .PCWr(pcwr_t), .npcop(npcop_t), .IRWr(irwr_t), .RFWr(rfwr_t), .R_sel(r_sel_t),
        .D_sel(d_sel_t), .sel(sel_t), .extop(extop_t), .aluop(aluop_t), .wren(wren_t),
        .illegal(illegal_t), .state_o(state_t_o)
    );

    always #5 clk = ~clk;

    wire [17:0] outs   = {pcwr, npcop, irwr, rfwr, r_sel, d_sel, sel, extop, aluop, wren, illegal};
    wire [17:0] outs_t = {pcwr_t, npcop_t, irwr_t, rfwr_t, r_sel_t, d_sel_t, sel_t, extop_t,
                          aluop_t, wren_t, illegal_t};

    function automatic logic [17:0] po(input logic pc, input logic [1:0] npc, input logic ir,
                                       input logic rf, input logic [1:0] rs, input logic [1:0] ds,
                                       input logic sl, input logic [1:0] ex, input logic [3:0] al,
                                       input logic wr, input logic il);
        return {pc, npc, ir, rf, rs, ds, sl, ex, al, wr, il};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [3:0] st, input logic [17:0] o);
        chk({tag, "_st"}, {28'd0, state_o}, {28'd0, st});
        chk({tag, "_o"}, {14'd0, outs}, {14'd0, o});
        step();
    endtask

    task automatic fetch(input string tag);
        cyc({tag, "_if0"}, ST_IF0, 18'd0);
        cyc({tag, "_if1"}, ST_IF1, po(1, 2'b00, 1, 0, 2'b00, 2'b00, 0, 2'b00, 4'h0, 0, 0));
        cyc({tag, "_id"}, ST_ID, 18'd0);
    endtask

    task automatic alu_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                             input logic sl, input logic [1:0] ex, input logic [3:0] al,
                             input logic [1:0] rs);
        op = o;
        funct = f;
        fetch(tag);
        cyc({tag, "_ex"}, ST_EX, po(0, 2'b00, 0, 0, 2'b00, 2'b00, sl, ex, al, 0, 0));
        cyc({tag, "_wb"}, ST_WB, po(0, 2'b00, 0, 1, rs, 2'b01, sl, ex, al, 0, 0));
        chk({tag, "_done"}, {28'd0, state_o}, {28'd0, ST_IF0});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) step();
        chk("rst_st", {28'd0, state_o}, {28'd0, ST_RST});
        chk("rst_o", {14'd0, outs}, 18'd0);
        rst = 1'b1;
        step();
        chk("boot_if0", {28'd0, state_o}, {28'd0, ST_IF0});

        zero = 1'b1;
        alu_instr("addu", 6'h00, 6'h21, 0, 2'b00, 4'h0, 2'b10);
        alu_instr("subu", 6'h00, 6'h23, 0, 2'b00, 4'h1, 2'b10);
        alu_instr("slt", 6'h00, 6'h2A, 0, 2'b00, 4'h4, 2'b10);
        alu_instr("ori", 6'h0D, 6'h00, 1, 2'b00, 4'h3, 2'b01);
        alu_instr("addiu", 6'h09, 6'h3F, 1, 2'b01, 4'h0, 2'b01);
        alu_instr("lui", 6'h0F, 6'h00, 1, 2'b10, 4'h3, 2'b01);

        op = 6'h23;
        fetch("lw");
        cyc("lw_ma", ST_MA, po(0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 2'b01, 4'h0, 0, 0));
        cyc("lw_mr", ST_MR, 18'd0);
        cyc("lw_mwb", ST_MWB, po(0, 2'b00, 0, 1, 2'b01, 2'b10, 0, 2'b00, 4'h0, 0, 0));
        chk("lw_done", {28'd0, state_o}, {28'd0, ST_IF0});

        op = 6'h2B;
        fetch("sw");
        cyc("sw_ma", ST_MA, po(0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 2'b01, 4'h0, 0, 0));
        cyc("sw_mw", ST_MW, po(0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 4'h0, 1, 0));
        chk("sw_done", {28'd0, state_o}, {28'd0, ST_IF0});

        op = 6'h04;
        zero = 1'b1;
        fetch("beq1");
        cyc("beq1_br", ST_BR, po(1, 2'b01, 0, 0, 2'b00, 2'b00, 0, 2'b00, 4'h1, 0, 0));
        chk("beq1_done", {28'd0, state_o}, {28'd0, ST_IF0});
        zero = 1'b0;
        fetch("beq0");
        cyc("beq0_br", ST_BR, po(0, 2'b01, 0, 0, 2'b00, 2'b00, 0, 2'b00, 4'h1, 0, 0));
        chk("beq0_done", {28'd0, state_o}, {28'd0, ST_IF0});

        op = 6'h03;
        fetch("jal");
        cyc("jal_jmp", ST_JMP, po(1, 2'b10, 0, 1, 2'b00, 2'b00, 0, 2'b00, 4'h0, 0, 0));
        op = 6'h00;
        funct = 6'h08;
        fetch("jr");
        cyc("jr_jmp", ST_JMP, po(1, 2'b11, 0, 0, 2'b00, 2'b00, 0, 2'b00, 4'h0, 0, 0));
        op = 6'h02;
        fetch("j");
        cyc("j_jmp", ST_JMP, po(1, 2'b10, 0, 0, 2'b00, 2'b00, 0, 2'b00, 4'h0, 0, 0));
        chk("j_done", {28'd0, state_o}, {28'd0, ST_IF0});

        op = 6'h3F;
        funct = 6'h00;
        chk("trap_sync", {28'd0, state_t_o}, {28'd0, ST_IF0});
        cyc("ill_if0", ST_IF0, 18'd0);
        cyc("ill_if1", ST_IF1, po(1, 2'b00, 1, 0, 2'b00, 2'b00, 0, 2'b00, 4'h0, 0, 0));
        chk("trap_id_o", {14'd0, outs_t}, 18'd1);
        cyc("ill_id", ST_ID, 18'd1);
        chk("trap_halt", {28'd0, state_t_o}, {28'd0, ST_HALT});
        op = 6'h2B;
        fetch("sw2");
        chk("trap_hold_st", {28'd0, state_t_o}, {28'd0, ST_HALT});
        chk("trap_hold_o", {14'd0, outs_t}, 18'd0);
        cyc("sw2_ma", ST_MA, po(0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 2'b01, 4'h0, 0, 0));
        chk("sw2_mw_wren", {31'd0, wren}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_wren", {31'd0, wren}, 32'd0);
        chk("midrst_st", {28'd0, state_o}, {28'd0, ST_RST});
        chk("midrst_o", {14'd0, outs}, 18'd0);
        chk("midrst_trap_st", {28'd0, state_t_o}, {28'd0, ST_RST});
        step();
        rst = 1'b1;
        step();
        chk("rerun_if0", {28'd0, state_o}, {28'd0, ST_IF0});
        chk("rerun_trap_if0", {28'd0, state_t_o}, {28'd0, ST_IF0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
